mem_dump_reader: RTL

Memory readback engine for the single-cycle CPU test environment: the read-out counterpart of the `$readmemh` image load. On a start command it reads a contiguous window of the word-addressed CPU memory through a synchronous-read port. Each word goes out, with its address, on a valid/ready stream. A host, logger or UART bridge can then dump the `.data` segment (word address 2048 onward) after a program has run.

---
 rtl/mem_dump_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_dump_reader.sv
// Purpose  : reads a window of word-addressed memory and streams each word with its address.
// Latency  : start -> first read strobe 1 cycle, 3 cycles per word with out_ready high, done 1 cycle after last handshake.
// Backpress: out_ready low in PRESENT holds out_addr/out_data/out_last stable; each stall cycle adds one cycle per word.
//
// Build option: define MEM_DUMP_CHECKSUM_EN to enable the running checksum of emitted words;
// when undefined, checksum is tied to 0 and no adder exists.
//
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   start             : begin a dump (only honoured in IDLE)
//   base_addr         : first word address, latched on accepted start
//   word_count        : number of words (0..2^ADDR_W), latched on accepted start
//   abort             : synchronous cancel of an active dump
//   busy, done        : dump in progress / one-cycle completion pulse
//   mem_rd_en/addr    : synchronous-read memory port request (data returns next cycle)
//   mem_rd_data       : memory read data
//   out_valid/ready   : output stream handshake
//   out_addr/data/last: presented word, its address, final-word flag
//   checksum          : running sum of emitted words (0 when feature disabled)

module mem_dump_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W:0]     r_rem;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_en;
  // Doubles as the address counter: it always holds the address of the
  // word currently being fetched or presented.
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_out_valid;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;

  logic                w_hs;
  logic                w_start_ok;

  assign w_hs       = r_out_valid & out_ready;
  assign w_start_ok = (r_state == S_IDLE) & start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem      <= word_count;
            r_mem_addr <= base_addr;
            if (word_count == '0) begin
              // Empty window: skip straight to the completion pulse.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_busy  <= 1'b1;
              r_rd_en <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
          end else begin
            r_rd_en <= 1'b0;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            // Memory data for the ISSUE-cycle address is valid now.
            r_out_data  <= mem_rd_data;
            r_out_addr  <= r_mem_addr;
            r_out_last  <= (r_rem == (ADDR_W+1)'(1));
            r_out_valid <= 1'b1;
            r_state     <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          if (abort) begin
            // Abort beats a coincident final handshake: no done pulse.
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
            r_rem       <= r_rem - (ADDR_W+1)'(1);
            if (r_out_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_ISSUE;
              r_rd_en <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // start is deliberately ignored here; the next dump needs IDLE.
          r_state <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Cleared on an accepted start; abort leaves the partial sum visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if ((r_state == S_PRESENT) && w_hs && !abort) begin
      r_checksum <= r_checksum + r_out_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_mem_addr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule
